// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI channel-read protocol.
package a2d_pkg;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    IDLE    = 2'd1,
    ACTIVE  = 2'd2
  } serf_state_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;
  localparam int         FRAME_W  = 16;

  // Command frame a master sends to select channel ch.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for async SPI pins, plus an edge-detecting wrapper.
module spi_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STG-1:0] stg_r;

  // Shift the async pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_r <= {SYNC_STG{1'b0}};
    end else begin
      stg_r <= {stg_r[SYNC_STG-2:0], async_in};
    end
  end

  assign sync_out = stg_r[SYNC_STG-1];

endmodule

module spi_edge_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic sync_s;
  logic prev_r;

  spi_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (async_in),
    .sync_out (sync_s)
  );

  // Delay the synced level by one clk for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sync_s;
    end
  end

  assign sync_out = sync_s;
  assign rise     = sync_s & ~prev_r;
  assign fall     = ~sync_s & prev_r;

endmodule

// File: rtl/a2d_spi_serf.sv
// SPI responder for the A2D channel-read protocol: latches a channel from a
// 16-bit command frame and returns that channel's result on the next frame.
module a2d_spi_serf
  import a2d_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 12,
  parameter int SYNC_STG = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [2:0]               cmd_ch,
  output logic                     cmd_vld,
  output logic                     frm_err,
  output logic                     busy
);

  serf_state_t          state_r;
  logic [4:0]           bit_cnt_r;
  logic [FRAME_W-1:0]   rx_shft_r;
  logic [FRAME_W-1:0]   tx_shft_r;
  logic                 miso_r;
  logic [2:0]           cmd_ch_r;
  logic                 cmd_vld_r;
  logic                 frm_err_r;
  logic                 busy_r;

  logic                 ss_n_s;
  logic                 ss_rise_s;
  logic                 ss_fall_s;
  logic                 sclk_s;
  logic                 sclk_rise_s;
  logic                 sclk_fall_s;
  logic                 mosi_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic [FRAME_W-1:0]   tx_load_s;

  spi_edge_sync #(.SYNC_STG(SYNC_STG)) u_ss_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SS_n),
    .sync_out (ss_n_s),
    .rise     (ss_rise_s),
    .fall     (ss_fall_s)
  );

  spi_edge_sync #(.SYNC_STG(SYNC_STG)) u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SCLK),
    .sync_out (sclk_s),
    .rise     (sclk_rise_s),
    .fall     (sclk_fall_s)
  );

  spi_sync #(.SYNC_STG(SYNC_STG)) u_mosi_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (MOSI),
    .sync_out (mosi_s)
  );

  // Select the latched channel's result; unpopulated channels read as zero.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    if (int'({29'd0, cmd_ch_r}) < NUM_CH) begin
      sel_data_s = ch_data[int'(cmd_ch_r)*DATA_W +: DATA_W];
    end else begin
      sel_data_s = {DATA_W{1'b0}};
    end
    tx_load_s = {{(FRAME_W-DATA_W){1'b0}}, sel_data_s};
  end

  // Frame FSM, shifters, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= WAIT_HI;
      bit_cnt_r <= 5'd0;
      rx_shft_r <= {FRAME_W{1'b0}};
      tx_shft_r <= {FRAME_W{1'b0}};
      miso_r    <= 1'b0;
      cmd_ch_r  <= 3'd0;
      cmd_vld_r <= 1'b0;
      frm_err_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      cmd_vld_r <= 1'b0;
      frm_err_r <= 1'b0;
      case (state_r)
        // Reset may land mid-frame: hold off until the master deselects.
        WAIT_HI: begin
          miso_r <= 1'b0;
          busy_r <= 1'b0;
          if (ss_n_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_HI;
          end
        end
        IDLE: begin
          if (ss_fall_s) begin
            state_r   <= ACTIVE;
            busy_r    <= 1'b1;
            tx_shft_r <= tx_load_s;
            miso_r    <= tx_load_s[FRAME_W-1];
            bit_cnt_r <= 5'd0;
          end else begin
            miso_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        ACTIVE: begin
          // Deselect has priority over any SCLK edge seen in the same clk.
          if (ss_rise_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            miso_r  <= 1'b0;
            if (bit_cnt_r == 5'(FRAME_W)) begin
              cmd_ch_r  <= rx_shft_r[13:11];
              cmd_vld_r <= 1'b1;
            end else begin
              frm_err_r <= 1'b1;
            end
          end else if (sclk_rise_s) begin
            rx_shft_r <= {rx_shft_r[FRAME_W-2:0], mosi_s};
            if (bit_cnt_r != 5'd31) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end else if (sclk_fall_s && (bit_cnt_r != 5'd0)) begin
            tx_shft_r <= {tx_shft_r[FRAME_W-2:0], 1'b0};
            miso_r    <= tx_shft_r[FRAME_W-2];
          end
        end
        default: begin
          state_r <= WAIT_HI;
          miso_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign MISO    = miso_r;
  assign cmd_ch  = cmd_ch_r;
  assign cmd_vld = cmd_vld_r;
  assign frm_err = frm_err_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Directed bench for a2d_spi_serf: a mode-0 master model (SCLK = clk/32)
// driven from a vector table plus hand-written abort/snapshot/reset sequences.
module tb_a2d_spi_serf;
  import a2d_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] ch_data = 96'd0;
  logic [2:0]  cmd_ch;
  logic        cmd_vld;
  logic        frm_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  a2d_spi_serf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .ch_data (ch_data),
    .cmd_ch  (cmd_ch),
    .cmd_vld (cmd_vld),
    .frm_err (frm_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_vld) vld_cnt <= vld_cnt + 1;
    if (frm_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [15:0] mosi;
    int          nbits;
    logic [11:0] ch4;
    logic [15:0] exp_miso;
    int          exp_vld;
    int          exp_err;
    logic [2:0]  exp_ch;
  } vec_t;

  vec_t vecs[14];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [11:0] val);
    ch_data[k*12 +: 12] = val;
  endtask

  task automatic spi_bit(input logic mosi_v, output logic miso_v);
    MOSI = mosi_v;
    wait_clk(8);
    miso_v = MISO;
    SCLK = 1'b1;
    wait_clk(16);
    SCLK = 1'b0;
    wait_clk(8);
  endtask

  // One SS_n-low frame of nbits; ch4 is rewritten to chg_val before bit chg_bit.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int chg_bit,
                           input logic [11:0] chg_val, output logic [15:0] rd,
                           output int dv, output int de);
    logic m;
    int v0, e0;
    v0 = vld_cnt;
    e0 = err_cnt;
    rd = 16'h0000;
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) set_ch(4, chg_val);
      spi_bit((i < 16) ? word[15-i] : 1'b0, m);
      if (i < 16) rd = {rd[14:0], m};
    end
    SS_n = 1'b1;
    wait_clk(12);
    dv = vld_cnt - v0;
    de = err_cnt - e0;
  endtask

  initial begin
    logic [15:0] rd;
    logic        m;
    int          dv, de, v0, e0;

    vecs[0]  = '{16'h2000, 16, 12'hA5C, 16'h0123, 1, 0, 3'd4};
    vecs[1]  = '{16'h0000, 16, 12'hA5C, 16'h0A5C, 1, 0, 3'd0};
    vecs[2]  = '{16'h0000, 16, 12'h456, 16'h0123, 1, 0, 3'd0};
    vecs[3]  = '{16'h0000, 16, 12'h456, 16'h0123, 1, 0, 3'd0};
    vecs[4]  = '{a2d_cmd(CH_RGHT), 16, 12'h456, 16'h0123, 1, 0, 3'd4};
    vecs[5]  = '{16'h2000, 16, 12'h456, 16'h0456, 1, 0, 3'd4};
    vecs[6]  = '{16'h2800, 16, 12'h456, 16'h0456, 1, 0, 3'd5};
    vecs[7]  = '{16'h2800, 16, 12'h456, 16'h0789, 1, 0, 3'd5};
    vecs[8]  = '{16'h3000, 16, 12'h456, 16'h0789, 1, 0, 3'd6};
    vecs[9]  = '{16'h3000, 16, 12'h456, 16'h0FFF, 1, 0, 3'd6};
    vecs[10] = '{16'h2800, 17, 12'h456, 16'h0FFF, 0, 1, 3'd6};
    vecs[11] = '{16'h3000, 16, 12'h456, 16'h0FFF, 1, 0, 3'd6};
    vecs[12] = '{16'hE7FF, 16, 12'h456, 16'h0FFF, 1, 0, 3'd4};
    vecs[13] = '{16'h2000, 16, 12'h456, 16'h0456, 1, 0, 3'd4};

    set_ch(0, 12'h123);
    set_ch(5, 12'h789);
    set_ch(6, 12'hFFF);

    wait_clk(4);
    chk("reset MISO", 32'(MISO), 32'd0);
    chk("reset cmd_ch", 32'(cmd_ch), 32'd0);
    chk("reset cmd_vld", 32'(cmd_vld), 32'd0);
    chk("reset frm_err", 32'(frm_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 14; i++) begin
      set_ch(4, vecs[i].ch4);
      spi_frame(vecs[i].mosi, vecs[i].nbits, -1, 12'h000, rd, dv, de);
      chk($sformatf("v%0d miso", i), 32'(rd), 32'(vecs[i].exp_miso));
      chk($sformatf("v%0d cmd_vld", i), 32'(dv), 32'(vecs[i].exp_vld));
      chk($sformatf("v%0d frm_err", i), 32'(de), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d cmd_ch", i), 32'(cmd_ch), 32'(vecs[i].exp_ch));
      chk($sformatf("v%0d MISO idle", i), 32'(MISO), 32'd0);
      chk($sformatf("v%0d busy idle", i), 32'(busy), 32'd0);
    end

    // Abort after 9 bits while reading ch4 (0x0456): MISO holds bit 6 until deselect.
    v0 = vld_cnt;
    e0 = err_cnt;
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 9; i++) spi_bit(1'b1, m);
    chk("abort busy", 32'(busy), 32'd1);
    chk("abort MISO pre", 32'(MISO), 32'd1);
    SS_n = 1'b1;
    wait_clk(12);
    chk("abort frm_err", 32'(err_cnt - e0), 32'd1);
    chk("abort cmd_vld", 32'(vld_cnt - v0), 32'd0);
    chk("abort cmd_ch", 32'(cmd_ch), 32'd4);
    chk("abort MISO post", 32'(MISO), 32'd0);
    spi_frame(16'h3000, 16, -1, 12'h000, rd, dv, de);
    chk("post-abort miso", 32'(rd), 32'h0456);
    chk("post-abort vld", 32'(dv), 32'd1);
    chk("post-abort cmd_ch", 32'(cmd_ch), 32'd6);

    // Snapshot: ch4 changes mid read frame.
    spi_frame(16'h2000, 16, -1, 12'h000, rd, dv, de);
    chk("snap select", 32'(cmd_ch), 32'd4);
    spi_frame(16'h2000, 16, 5, 12'h999, rd, dv, de);
    chk("snap miso", 32'(rd), 32'h0456);
    spi_frame(16'h2000, 16, -1, 12'h000, rd, dv, de);
    chk("snap next miso", 32'(rd), 32'h0999);

    // Reset mid-frame with SS_n held low.
    v0 = vld_cnt;
    e0 = err_cnt;
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    chk("rst mid MISO", 32'(MISO), 32'd0);
    chk("rst mid cmd_ch", 32'(cmd_ch), 32'd0);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid MISO2", 32'(MISO), 32'd0);
    SS_n = 1'b1;
    wait_clk(12);
    chk("rst mid vld", 32'(vld_cnt - v0), 32'd0);
    chk("rst mid err", 32'(err_cnt - e0), 32'd0);
    spi_frame(16'h3000, 16, -1, 12'h000, rd, dv, de);
    chk("rst fresh miso", 32'(rd), 32'h0123);
    chk("rst fresh vld", 32'(dv), 32'd1);
    chk("rst fresh cmd_ch", 32'(cmd_ch), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
